raycast_scheduler: RTL and testbench

// - Sequences the raycaster core once per video frame: issues one ray per screen column, collects wall height/side, writes it into the back bank of a 2-bank column buffer.
// - Swaps the displayed bank at frame boundary only when a full frame is complete, so VGA never shows a half-rendered frame.
// - Sits between game FSM (enable = play state), player movement (pose) and raycaster core / column buffer.

---
 rtl/raycast_scheduler_pkg.sv | 30 +++
 rtl/raycast_scheduler.sv | 129 ++++++++++++
 tb/tb_raycast_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raycast_scheduler_pkg.sv
// Shared constants, FSM encoding and column-buffer word layout for the raycast frame scheduler.
package raycast_scheduler_pkg;

  localparam int H_RES    = 640;
  localparam int COL_W    = 10;
  localparam int POS_W    = 16;
  localparam int ANGLE_W  = 12;
  localparam int HEIGHT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // One column-buffer entry: shading side above the wall height.
  typedef struct packed {
    logic                side;
    logic [HEIGHT_W-1:0] height;
  } col_word_t;

  // Ray angle for a column: centred on the view angle, wrapping modulo 2**ANGLE_W.
  function automatic logic [ANGLE_W-1:0] ray_angle(input logic [ANGLE_W-1:0] ang,
                                                   input logic [COL_W-1:0]   col);
    return ang + ANGLE_W'(col) - ANGLE_W'(H_RES / 2);
  endfunction

endpackage

// File: rtl/raycast_scheduler.sv
// Per-frame ray sequencer: casts one ray per column into the back bank of a
// double-buffered column store and flips banks only after a complete frame.
module raycast_scheduler
  import raycast_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_start,
  input  logic [POS_W-1:0]    player_x,
  input  logic [POS_W-1:0]    player_y,
  input  logic [ANGLE_W-1:0]  player_ang,
  output logic                ray_start,
  output logic [COL_W-1:0]    ray_col,
  output logic [POS_W-1:0]    ray_x,
  output logic [POS_W-1:0]    ray_y,
  output logic [ANGLE_W-1:0]  ray_ang,
  input  logic                ray_done,
  input  logic [HEIGHT_W-1:0] ray_height,
  input  logic                ray_side,
  output logic                wr_en,
  output logic [COL_W:0]      wr_addr,
  output logic [HEIGHT_W:0]   wr_data,
  output logic                disp_bank,
  output logic                busy,
  output logic                overrun
);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [POS_W-1:0]   pos_x_q, pos_x_d;
  logic [POS_W-1:0]   pos_y_q, pos_y_d;
  logic [ANGLE_W-1:0] ang_q, ang_d;
  col_word_t          word_q, word_d;
  logic               disp_bank_q, disp_bank_d;
  logic               frame_complete_q, frame_complete_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      col_q            <= '0;
      pos_x_q          <= '0;
      pos_y_q          <= '0;
      ang_q            <= '0;
      word_q           <= '0;
      disp_bank_q      <= 1'b0;
      frame_complete_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every flop samples its pre-edge inputs.
      state_q          <= state_d;
      col_q            <= col_d;
      pos_x_q          <= pos_x_d;
      pos_y_q          <= pos_y_d;
      ang_q            <= ang_d;
      word_q           <= word_d;
      disp_bank_q      <= disp_bank_d;
      frame_complete_q <= frame_complete_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d          = state_q;
    col_d            = col_q;
    pos_x_d          = pos_x_q;
    pos_y_d          = pos_y_q;
    ang_d            = ang_q;
    word_d           = word_q;
    disp_bank_d      = disp_bank_q;
    frame_complete_d = frame_complete_q;
    ray_start        = 1'b0;
    wr_en            = 1'b0;
    wr_addr          = '0;
    wr_data          = '0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start && enable) begin
          if (frame_complete_q) begin
            disp_bank_d      = ~disp_bank_q;
            frame_complete_d = 1'b0;
          end
          pos_x_d = player_x;
          pos_y_d = player_y;
          ang_d   = player_ang;
          col_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ray_start = 1'b1;
        state_d   = S_WAIT;
      end
      // A ray_done coincident with ray_start lands in ISSUE and is deliberately dropped.
      S_WAIT: begin
        if (ray_done) begin
          word_d  = '{side: ray_side, height: ray_height};
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {~disp_bank_q, col_q};
        wr_data = word_q;
        if (col_q == COL_W'(H_RES - 1)) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = enable ? S_ISSUE : S_IDLE;
        end
      end
      S_DONE: begin
        frame_complete_d = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ray fields read as zero while idle; during a frame they hold from ISSUE through ray_done.
  assign busy      = (state_q != S_IDLE);
  assign overrun   = frame_start & busy;
  assign disp_bank = disp_bank_q;
  assign ray_col   = busy ? col_q : '0;
  assign ray_x     = busy ? pos_x_q : '0;
  assign ray_y     = busy ? pos_y_q : '0;
  assign ray_ang   = busy ? ray_angle(ang_q, col_q) : '0;

endmodule

// File: tb/tb_raycast_scheduler.sv
// Directed bench for raycast_scheduler with a fixed-latency raycaster model and write monitor.
module tb_raycast_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] player_x = '0;
  logic [15:0] player_y = '0;
  logic [11:0] player_ang = '0;
  logic        ray_start;
  logic [9:0]  ray_col;
  logic [15:0] ray_x, ray_y;
  logic [11:0] ray_ang;
  logic        ray_done = 1'b0;
  logic [8:0]  ray_height = '0;
  logic        ray_side = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [9:0]  wr_data;
  logic        disp_bank, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor / model bookkeeping
  int          wr_count, start_count, seq_err, data_err, stable_err, base;
  logic [10:0] first_addr, last_addr;
  logic [11:0] ang_at [0:1023];
  logic [15:0] x_at_last, y_at_last;

  raycast_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .player_x(player_x), .player_y(player_y), .player_ang(player_ang),
    .ray_start(ray_start), .ray_col(ray_col), .ray_x(ray_x), .ray_y(ray_y),
    .ray_ang(ray_ang), .ray_done(ray_done), .ray_height(ray_height),
    .ray_side(ray_side), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_bank(disp_bank), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Raycaster model: result 4 cycles after ray_start, height = col+7, side = col bit 1.
  always begin : rc_model
    logic [9:0]  c;
    logic [11:0] a;
    @(negedge clk);
    if (ray_start) begin
      c = ray_col;
      a = ray_ang;
      repeat (4) @(negedge clk);
      ray_done   = 1'b1;
      ray_height = c[8:0] + 9'd7;
      ray_side   = c[1];
      if (ray_col !== c || ray_ang !== a) stable_err++;
      @(negedge clk);
      ray_done = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    logic [9:0] c;
    if (ray_start) begin
      start_count++;
      ang_at[ray_col] = ray_ang;
      if (ray_col == 10'd639) begin
        x_at_last = ray_x;
        y_at_last = ray_y;
      end
    end
    if (wr_en) begin
      if (wr_count == 0) first_addr = wr_addr;
      last_addr = wr_addr;
      if (wr_addr !== 11'(base + wr_count)) seq_err++;
      c = wr_addr[9:0];
      if (wr_data !== {c[1], c[8:0] + 9'd7}) data_err++;
      wr_count++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic reset_mon(input int b);
    base = b; wr_count = 0; start_count = 0; seq_err = 0; data_err = 0; stable_err = 0;
    first_addr = '0; last_addr = '0;
  endtask

  task automatic pulse_fs(output logic ov, output logic db_before);
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    ov        = overrun;
    db_before = disp_bank;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 6000) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, c);
    end
  endtask

  task automatic wait_start_col(input int col);
    int c = 0;
    while (!(ray_start === 1'b1 && ray_col == 10'(col)) && c < 6000) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (!(ray_start === 1'b1 && ray_col == 10'(col))) begin
      n_fail++;
      $display("FAIL wait_col%0d_timeout: ray_col=%0d, required ray_start at col %0d", col, ray_col, col);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, disp_bank, wr_en, ray_start, overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000", {busy, disp_bank, wr_en, ray_start, overrun});
    end
    n_checks++;
    if (ray_ang !== 12'd0 || ray_x !== 16'd0 || ray_col !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ray: ang=%0d x=%0d col=%0d, required 0", ray_ang, ray_x, ray_col);
    end
    n_checks++;
    if (wr_addr !== 11'd0 || wr_data !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_wr: addr=%0d data=%0d, required 0", wr_addr, wr_data);
    end
  endtask

  task automatic test_first_frame;
    logic ov, db;
    enable     = 1'b1;
    player_x   = 16'h1234;
    player_y   = 16'h5678;
    player_ang = 12'd10;
    reset_mon(1024);
    pulse_fs(ov, db);
    player_x   = 16'hFFFF;
    player_y   = 16'h0001;
    player_ang = 12'd2000;
    n_checks++;
    if (ov !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL f1_start: overrun=%b busy=%b, required 0/1", ov, busy);
    end
    wait_idle("f1");
    n_checks++;
    if (wr_count !== 640 || start_count !== 640) begin
      n_fail++;
      $display("FAIL f1_count: writes=%0d starts=%0d, required 640/640", wr_count, start_count);
    end
    n_checks++;
    if (first_addr !== 11'd1024 || last_addr !== 11'd1663 || seq_err !== 0) begin
      n_fail++;
      $display("FAIL f1_addr: first=%0d last=%0d seq_err=%0d, required 1024/1663/0", first_addr, last_addr, seq_err);
    end
    n_checks++;
    if (data_err !== 0 || stable_err !== 0) begin
      n_fail++;
      $display("FAIL f1_data: data_err=%0d stable_err=%0d, required 0/0", data_err, stable_err);
    end
    n_checks++;
    if (disp_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL f1_no_swap: disp_bank=%b, required 0", disp_bank);
    end
    n_checks++;
    if (ang_at[0] !== 12'd3786 || ang_at[320] !== 12'd10 || ang_at[639] !== 12'd329) begin
      n_fail++;
      $display("FAIL f1_ang: col0=%0d col320=%0d col639=%0d, required 3786/10/329", ang_at[0], ang_at[320], ang_at[639]);
    end
    n_checks++;
    if (x_at_last !== 16'h1234 || y_at_last !== 16'h5678) begin
      n_fail++;
      $display("FAIL f1_pose_latch: x=%h y=%h, required 1234/5678", x_at_last, y_at_last);
    end
  endtask

  task automatic test_second_frame;
    logic ov, db;
    reset_mon(0);
    pulse_fs(ov, db);
    n_checks++;
    if (db !== 1'b0 || disp_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL f2_swap: before=%b after=%b, required 0/1", db, disp_bank);
    end
    wait_idle("f2");
    n_checks++;
    if (wr_count !== 640 || first_addr !== 11'd0 || last_addr !== 11'd639 || seq_err !== 0) begin
      n_fail++;
      $display("FAIL f2_addr: writes=%0d first=%0d last=%0d seq_err=%0d, required 640/0/639/0", wr_count, first_addr, last_addr, seq_err);
    end
    n_checks++;
    if (ang_at[639] !== 12'(2000 + 639 - 320)) begin
      n_fail++;
      $display("FAIL f2_relatch_ang: col639=%0d, required 2319", ang_at[639]);
    end
  endtask

  task automatic test_overrun;
    logic ov, db;
    reset_mon(1024);
    pulse_fs(ov, db);
    n_checks++;
    if (disp_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_swap_in: disp_bank=%b, required 0", disp_bank);
    end
    wait_start_col(200);
    pulse_fs(ov, db);
    n_checks++;
    if (ov !== 1'b1 || disp_bank !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_pulse: overrun=%b disp_bank=%b busy=%b, required 1/0/1", ov, disp_bank, busy);
    end
    @(negedge clk);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_one_cycle: overrun=%b, required 0", overrun);
    end
    wait_idle("ovr");
    n_checks++;
    if (wr_count !== 640 || last_addr !== 11'd1663 || seq_err !== 0 || disp_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_complete: writes=%0d last=%0d seq_err=%0d disp_bank=%b, required 640/1663/0/0", wr_count, last_addr, seq_err, disp_bank);
    end
  endtask

  task automatic test_enable_drop;
    logic ov, db;
    reset_mon(0);
    pulse_fs(ov, db);
    n_checks++;
    if (db !== 1'b0 || disp_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL en_swap_after_ovr: before=%b after=%b, required 0/1", db, disp_bank);
    end
    wait_start_col(100);
    @(negedge clk);
    enable = 1'b0;
    wait_idle("en");
    repeat (20) @(negedge clk);
    n_checks++;
    if (wr_count !== 101 || start_count !== 101 || last_addr !== 11'd100) begin
      n_fail++;
      $display("FAIL en_abandon: writes=%0d starts=%0d last=%0d, required 101/101/100", wr_count, start_count, last_addr);
    end
    pulse_fs(ov, db);
    n_checks++;
    if (disp_bank !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_fs_disabled: disp_bank=%b busy=%b, required 1/0", disp_bank, busy);
    end
    enable = 1'b1;
    reset_mon(0);
    pulse_fs(ov, db);
    n_checks++;
    if (disp_bank !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL en_no_swap_partial: disp_bank=%b busy=%b, required 1/1", disp_bank, busy);
    end
  endtask

  task automatic test_reset_mid_ray;
    wait_start_col(3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reset_mon(0);
    repeat (12) @(negedge clk);
    n_checks++;
    if (wr_count !== 0 || start_count !== 0) begin
      n_fail++;
      $display("FAIL rst_stray_done: writes=%0d starts=%0d, required 0/0", wr_count, start_count);
    end
    n_checks++;
    if ({busy, disp_bank, wr_en, ray_start} !== 4'b0 || ray_ang !== 12'd0) begin
      n_fail++;
      $display("FAIL rst_outputs: flags=%b ang=%0d, required 0000/0", {busy, disp_bank, wr_en, ray_start}, ray_ang);
    end
  endtask

  initial begin
    reset_mon(0);
    test_reset;
    test_first_frame;
    test_second_frame;
    test_overrun;
    test_enable_drop;
    test_reset_mid_ray;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
